// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one bin2BCD converter between operand entry (A)
// and ALU result (B); latches converted digits into held display registers.
module bcd_conv_arbiter #(
  parameter int WIDTH       = 16,
  parameter int CONV_CYCLES = 18,
  parameter int MAX_VAL     = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] bin_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] bin_b,
  output logic             ack_a,
  output logic             ack_b,
  output logic [WIDTH-1:0] conv_bin,
  output logic             conv_start,
  input  logic [3:0]       conv_d1000,
  input  logic [3:0]       conv_d100,
  input  logic [3:0]       conv_d10,
  input  logic [3:0]       conv_d1,
  output logic [3:0]       disp_d1000,
  output logic [3:0]       disp_d100,
  output logic [3:0]       disp_d10,
  output logic [3:0]       disp_d1,
  output logic             disp_src,
  output logic             disp_upd,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [WIDTH-1:0] MAX_BIN = MAX_VAL[WIDTH-1:0];
  localparam logic [CW-1:0]    CNT_INIT = CW'(CONV_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, START, WAIT, CAPTURE, OVF} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             last_grant;  // 1 = B was granted last
  logic             sel;
  logic             grant_a;
  logic             grant_b;
  logic [WIDTH-1:0] grant_bin;

  // Grant is decided combinationally so the ack lands in the sampling cycle;
  // it is masked during reset so every output reads 0 while rst is high.
  always_comb begin
    // NOTE: default every always_comb output first so no path infers a latch.
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst && state == IDLE) begin
      if (req_a && req_b) begin
        grant_a = last_grant;
        grant_b = !last_grant;
      end else begin
        grant_a = req_a;
        grant_b = req_b;
      end
    end
  end

  assign grant_bin = grant_b ? bin_b : bin_a;
  assign ack_a     = grant_a;
  assign ack_b     = grant_b;

  // NOTE: sequential state uses non-blocking (<=) so every register updates
  // from pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      last_grant <= 1'b1;
      sel        <= 1'b0;
      conv_bin   <= '0;
      conv_start <= 1'b0;
      disp_d1000 <= '0;
      disp_d100  <= '0;
      disp_d10   <= '0;
      disp_d1    <= '0;
      disp_src   <= 1'b0;
      disp_upd   <= 1'b0;
      ovf        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      conv_start <= 1'b0;
      disp_upd   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_a || grant_b) begin
            conv_bin   <= grant_bin;
            sel        <= grant_b;
            last_grant <= grant_b;
            busy       <= 1'b1;
            if (grant_bin > MAX_BIN) begin
              state <= OVF;
            end else begin
              state      <= START;
              conv_start <= 1'b1;
            end
          end
        end
        START: begin
          count <= CNT_INIT;
          state <= WAIT;
        end
        WAIT: begin
          if (count == '0) state <= CAPTURE;
          else             count <= count - 1'b1;
        end
        CAPTURE: begin
          disp_d1000 <= conv_d1000;
          disp_d100  <= conv_d100;
          disp_d10   <= conv_d10;
          disp_d1    <= conv_d1;
          disp_src   <= sel;
          ovf        <= 1'b0;
          disp_upd   <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        OVF: begin
          disp_d1000 <= 4'hE;
          disp_d100  <= 4'hE;
          disp_d10   <= 4'hE;
          disp_d1    <= 4'hE;
          disp_src   <= sel;
          ovf        <= 1'b1;
          disp_upd   <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter with a behavioural fixed-latency bin2BCD
// model whose digits read 4'hF until CONV_CYCLES cycles after each start.
module tb_bcd_conv_arbiter;

  localparam int WIDTH = 16;
  localparam int CC    = 18;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_a, req_b;
  logic [WIDTH-1:0] bin_a, bin_b;
  logic             ack_a, ack_b;
  logic [WIDTH-1:0] conv_bin;
  logic             conv_start;
  logic [3:0]       conv_d1000, conv_d100, conv_d10, conv_d1;
  logic [3:0]       disp_d1000, disp_d100, disp_d10, disp_d1;
  logic             disp_src, disp_upd, ovf, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_conv_arbiter #(.WIDTH(WIDTH), .CONV_CYCLES(CC), .MAX_VAL(9999)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_a      (req_a),
    .bin_a      (bin_a),
    .req_b      (req_b),
    .bin_b      (bin_b),
    .ack_a      (ack_a),
    .ack_b      (ack_b),
    .conv_bin   (conv_bin),
    .conv_start (conv_start),
    .conv_d1000 (conv_d1000),
    .conv_d100  (conv_d100),
    .conv_d10   (conv_d10),
    .conv_d1    (conv_d1),
    .disp_d1000 (disp_d1000),
    .disp_d100  (disp_d100),
    .disp_d10   (disp_d10),
    .disp_d1    (disp_d1),
    .disp_src   (disp_src),
    .disp_upd   (disp_upd),
    .ovf        (ovf),
    .busy       (busy)
  );

  // Converter model: digits become valid CC cycles after the start pulse.
  logic [WIDTH-1:0] cval    = '0;
  int               ccnt    = 0;
  logic             started = 1'b0;
  logic             ready;

  always @(posedge clk) begin
    if (conv_start) begin
      cval    <= conv_bin;
      ccnt    <= CC - 1;
      started <= 1'b1;
    end else if (ccnt > 0) begin
      ccnt <= ccnt - 1;
    end
  end

  assign ready      = started && (ccnt == 0);
  assign conv_d1000 = ready ? 4'((cval / 1000) % 10) : 4'hF;
  assign conv_d100  = ready ? 4'((cval / 100) % 10)  : 4'hF;
  assign conv_d10   = ready ? 4'((cval / 10) % 10)   : 4'hF;
  assign conv_d1    = ready ? 4'(cval % 10)          : 4'hF;

  function automatic logic [15:0] disp();
    return {disp_d1000, disp_d100, disp_d10, disp_d1};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  // Steps until disp_upd is seen; 'at' is the cycle number it appeared in.
  task automatic wait_upd(input int start_cyc, output int at);
    at = start_cyc;
    while (!disp_upd && at < start_cyc + 100) begin
      next_cycle();
      at++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int at;
    int busy_cnt;
    int n;
    int cyc;
    int gcyc[4];
    logic [3:0] seq;

    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; bin_a = '0; bin_b = '0;
    next_cycle(); next_cycle();
    check("reset_outputs",
          {ack_a, ack_b, conv_bin, conv_start, disp(), disp_src, disp_upd, ovf, busy}, '0);
    rst = 1'b0;
    next_cycle();

    // 1: single request A, 1111
    bin_a = 16'd1111; req_a = 1'b1; #1;
    check("t1_ack", {ack_a, ack_b, busy}, 3'b100);
    next_cycle(); req_a = 1'b0;
    check("t1_start", {conv_start, busy}, 2'b11);
    check("t1_conv_bin", conv_bin, 16'd1111);
    next_cycle();
    check("t1_start_pulse", conv_start, 1'b0);
    wait_upd(2, at);
    check("t1_upd_cycle", at, CC + 3);
    check("t1_disp", disp(), 16'h1111);
    check("t1_src_ovf_busy", {disp_src, ovf, busy}, 3'b000);
    next_cycle();
    check("t1_upd_pulse", disp_upd, 1'b0);
    check("t1_hold", disp(), 16'h1111);

    // 2: simultaneous requests after reset -> A first, then B
    rst = 1'b1; next_cycle(); rst = 1'b0;
    bin_a = 16'd1234; bin_b = 16'd42; req_a = 1'b1; req_b = 1'b1; #1;
    check("t2_tie_ack", {ack_a, ack_b}, 2'b10);
    next_cycle(); req_a = 1'b0;
    wait_upd(1, at);
    check("t2_a_upd_cycle", at, CC + 3);
    check("t2_a_disp", {disp(), 3'(disp_src)}, {16'h1234, 3'd0});
    check("t2_b_ack", {ack_a, ack_b}, 2'b01);
    next_cycle(); req_b = 1'b0;
    check("t2_b_conv_bin", conv_bin, 16'd42);
    wait_upd(1, at);
    check("t2_b_upd_cycle", at, CC + 3);
    check("t2_b_disp", {disp(), 3'(disp_src), 3'(ovf)}, {16'h0042, 3'd1, 3'd0});

    // 3: both held continuously -> A,B,A,B
    next_cycle();
    bin_a = 16'd5; bin_b = 16'd7; req_a = 1'b1; req_b = 1'b1; #1;
    n = 0; cyc = 0; seq = '0;
    while (n < 4 && cyc < 4 * (CC + 3) + 20) begin
      if (ack_a || ack_b) begin
        seq[n]  = ack_b;
        gcyc[n] = cyc;
        n++;
      end
      if (ack_a && ack_b) check("t3_double_ack", 2'b11, 2'b01);
      if (n < 4) begin
        next_cycle(); cyc++;
      end
    end
    check("t3_grant_count", n, 4);
    check("t3_order", seq, 4'b1010);
    check("t3_gap", gcyc[1] - gcyc[0], CC + 3);
    next_cycle(); req_a = 1'b0; req_b = 1'b0;
    wait_upd(1, at);
    check("t3_last_disp", {disp(), 3'(disp_src)}, {16'h0007, 3'd1});

    // 4: overflow on B, then max value on A
    next_cycle();
    bin_b = 16'd10000; req_b = 1'b1; #1;
    check("t4_ack", {ack_a, ack_b}, 2'b01);
    next_cycle(); req_b = 1'b0;
    check("t4_no_start", {conv_start, busy, disp_upd}, 3'b010);
    next_cycle();
    check("t4_ovf_disp", {disp_upd, ovf, disp_src, disp()}, {3'b111, 16'hEEEE});
    bin_a = 16'd9999; req_a = 1'b1; #1;
    check("t4_a_ack", ack_a, 1'b1);
    next_cycle(); req_a = 1'b0;
    check("t4_a_start", {conv_start, conv_bin}, {1'b1, 16'd9999});
    wait_upd(1, at);
    check("t4_a_upd_cycle", at, CC + 3);
    check("t4_a_disp", {disp(), 3'(ovf), 3'(disp_src)}, {16'h9999, 3'd0, 3'd0});

    // 5: reset during WAIT with req_a still held
    next_cycle();
    bin_a = 16'd321; req_a = 1'b1; #1;
    check("t5_ack", ack_a, 1'b1);
    for (int i = 0; i < 5; i++) next_cycle();
    check("t5_in_wait", {busy, disp_upd}, 2'b10);
    rst = 1'b1; #1;
    check("t5_ack_masked", {ack_a, ack_b}, 2'b00);
    next_cycle();
    check("t5_reset_outputs",
          {ack_a, ack_b, conv_bin, conv_start, disp(), disp_src, disp_upd, ovf, busy}, '0);
    rst = 1'b0; #1;
    check("t5_regrant", ack_a, 1'b1);
    next_cycle(); req_a = 1'b0;
    wait_upd(1, at);
    check("t5_upd_cycle", at, CC + 3);
    check("t5_disp", disp(), 16'h0321);

    // 6: zero value, busy window
    next_cycle();
    bin_a = 16'd0; req_a = 1'b1; #1;
    check("t6_ack_idle", {ack_a, busy}, 2'b10);
    next_cycle(); req_a = 1'b0;
    busy_cnt = 0; at = 1;
    while (!disp_upd && at < 100) begin
      if (busy) busy_cnt++;
      next_cycle(); at++;
    end
    check("t6_upd_cycle", at, CC + 3);
    check("t6_busy_cycles", busy_cnt, CC + 2);
    check("t6_disp", {disp(), 3'(ovf), 3'(busy)}, {16'h0000, 3'd0, 3'd0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
